// File: rtl/color_playback_sm.sv
// Color pattern sequencer for the "says" game: appends one LFSR color per round,
// then replays the stored sequence with timed show/blank slots.
module color_playback_sm #(
    parameter int unsigned MAX_LEN   = 9,
    parameter int unsigned ON_TICKS  = 25000000,
    parameter int unsigned OFF_TICKS = 12500000,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Start,
    input  logic       Clear,
    input  logic       Abort,
    input  logic [3:0] Rd_idx,
    output logic [2:0] Rd_color,
    output logic [2:0] Color_out,
    output logic [3:0] Seq_len,
    output logic       Busy,
    output logic       Done
);

    localparam int unsigned MaxTicks = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int unsigned TickW    = (MaxTicks > 1) ? $clog2(MaxTicks) : 1;
    localparam logic [TickW-1:0] OnLast  = TickW'(ON_TICKS - 1);
    localparam logic [TickW-1:0] OffLast = TickW'(OFF_TICKS - 1);
    localparam logic [3:0]       MaxLen  = 4'(MAX_LEN);

    typedef enum logic [2:0] {StIdle, StAppend, StShow, StGap, StDone} state_e;

    state_e           state_q, state_d;
    logic [3:0]       seq_len_q, seq_len_d;
    logic [3:0]       slot_q, slot_d;
    logic [TickW-1:0] tick_q, tick_d;
    logic [15:0]      lfsr_q, lfsr_d;
    logic [2:0]       rd_color_q, rd_color_d;
    logic [2:0]       mem_q [MAX_LEN];
    logic             mem_we;
    logic [2:0]       new_color;
    logic [2:0]       slot_color;

    // Fibonacci LFSR, taps 16,14,13,11 (right-shifting form)
    assign lfsr_d    = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    assign new_color = {1'b0, lfsr_q[1:0]} + 3'd1;

    always_comb begin
        slot_color = '0;
        rd_color_d = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (slot_q == 4'(i)) slot_color = mem_q[i];
            if ((Rd_idx == 4'(i)) && (Rd_idx < seq_len_q)) rd_color_d = mem_q[i];
        end
    end

    always_comb begin
        state_d   = state_q;
        seq_len_d = seq_len_q;
        slot_d    = slot_q;
        tick_d    = tick_q;
        mem_we    = 1'b0;
        Color_out = '0;
        Busy      = 1'b0;
        Done      = 1'b0;
        case (state_q)
            StIdle: begin
                // Clear lands before the append so Clear+Start yields a 1-entry round
                if (Clear) seq_len_d = '0;
                if (Start) state_d = StAppend;
            end
            StAppend: begin
                Busy = 1'b1;
                if (seq_len_q < MaxLen) begin
                    mem_we    = 1'b1;
                    seq_len_d = seq_len_q + 4'd1;
                end
                slot_d  = '0;
                tick_d  = '0;
                state_d = StShow;
            end
            StShow: begin
                Busy      = 1'b1;
                Color_out = slot_color;
                if (tick_q == OnLast) begin
                    tick_d  = '0;
                    state_d = StGap;
                end else begin
                    tick_d = tick_q + TickW'(1);
                end
            end
            StGap: begin
                Busy = 1'b1;
                if (tick_q == OffLast) begin
                    tick_d = '0;
                    if (slot_q + 4'd1 == seq_len_q) begin
                        state_d = StDone;
                    end else begin
                        slot_d  = slot_q + 4'd1;
                        state_d = StShow;
                    end
                end else begin
                    tick_d = tick_q + TickW'(1);
                end
            end
            StDone: begin
                Done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        if (Abort) state_d = StIdle;
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q    <= StIdle;
            seq_len_q  <= '0;
            slot_q     <= '0;
            tick_q     <= '0;
            lfsr_q     <= LFSR_SEED;
            rd_color_q <= '0;
        end else begin
            state_q    <= state_d;
            seq_len_q  <= seq_len_d;
            slot_q     <= slot_d;
            tick_q     <= tick_d;
            lfsr_q     <= lfsr_d;
            rd_color_q <= rd_color_d;
        end
    end

    // Storage needs no reset: entries at or beyond Seq_len are never observed
    always_ff @(posedge Clk) begin
        if (mem_we) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                if (seq_len_q == 4'(i)) mem_q[i] <= new_color;
            end
        end
    end

    assign Seq_len  = seq_len_q;
    assign Rd_color = rd_color_q;

endmodule

// File: tb/tb_color_playback_sm.sv
// Self-checking bench for color_playback_sm: cycle-exact playback scoreboard and LFSR model.
module tb_color_playback_sm;

    localparam int ON   = 3;
    localparam int OFF  = 2;
    localparam int MAXL = 9;

    logic       clk = 1'b0;
    logic       rst_n, start, clear, abort;
    logic [3:0] rd_idx;
    logic [2:0] rd_color, color_out;
    logic [3:0] seq_len;
    logic       busy, done;

    int checks   = 0;
    int failures = 0;

    logic [15:0] m_lfsr;
    logic [2:0]  exp_seq [16];
    int          exp_len = 0;
    logic [2:0]  sb [$];

    color_playback_sm #(
        .MAX_LEN  (MAXL),
        .ON_TICKS (ON),
        .OFF_TICKS(OFF),
        .LFSR_SEED(16'hACE1)
    ) dut (
        .Clk      (clk),
        .Reset    (rst_n),
        .Start    (start),
        .Clear    (clear),
        .Abort    (abort),
        .Rd_idx   (rd_idx),
        .Rd_color (rd_color),
        .Color_out(color_out),
        .Seq_len  (seq_len),
        .Busy     (busy),
        .Done     (done)
    );

    always #5 clk = ~clk;

    // Reference LFSR: 16-bit Fibonacci, taps 16,14,13,11
    always @(posedge clk) begin
        if (!rst_n) m_lfsr <= 16'hACE1;
        else        m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_append(input bit do_clear);
        if (do_clear) exp_len = 0;
        if (exp_len < MAXL) begin
            exp_seq[exp_len] = {1'b0, m_lfsr[1:0]} + 3'd1;
            exp_len++;
        end
    endtask

    // One full round: Start pulse, APPEND, whole playback, Done, back to idle.
    task automatic play_round(input bit do_clear, input bit start_in_show, input string tag);
        logic [2:0] cur;
        start = 1'b1;
        clear = do_clear;
        step();
        start = 1'b0;
        clear = 1'b0;
        model_append(do_clear);
        checks++;
        if ({color_out, busy, done} !== {3'd0, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL %s append: {color,busy,done}=%b required %b", tag,
                     {color_out, busy, done}, {3'd0, 1'b1, 1'b0});
        end
        for (int i = 0; i < exp_len; i++) sb.push_back(exp_seq[i]);
        for (int s = 0; s < exp_len; s++) begin
            cur = sb.pop_front();
            for (int k = 0; k < ON; k++) begin
                step();
                checks++;
                if ({color_out, busy, done} !== {cur, 1'b1, 1'b0}) begin
                    failures++;
                    $display("FAIL %s show slot%0d tick%0d: {color,busy,done}=%b required %b",
                             tag, s, k, {color_out, busy, done}, {cur, 1'b1, 1'b0});
                end
                if (start_in_show && s == 0) start = (k == 0);
            end
            start = 1'b0;
            for (int k = 0; k < OFF; k++) begin
                step();
                checks++;
                if ({color_out, busy, done} !== {3'd0, 1'b1, 1'b0}) begin
                    failures++;
                    $display("FAIL %s gap slot%0d tick%0d: {color,busy,done}=%b required %b",
                             tag, s, k, {color_out, busy, done}, {3'd0, 1'b1, 1'b0});
                end
            end
        end
        step();
        checks++;
        if ({color_out, busy, done, seq_len} !== {3'd0, 1'b0, 1'b1, 4'(exp_len)}) begin
            failures++;
            $display("FAIL %s done: {color,busy,done,len}=%b required %b", tag,
                     {color_out, busy, done, seq_len}, {3'd0, 1'b0, 1'b1, 4'(exp_len)});
        end
        step();
        checks++;
        if ({color_out, busy, done} !== 5'b0) begin
            failures++;
            $display("FAIL %s idle after done: {color,busy,done}=%b required 00000", tag,
                     {color_out, busy, done});
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b1;
        clear = 1'b0;
        abort = 1'b0;
        rd_idx = '0;
        repeat (3) step();
        checks++;
        if ({color_out, busy, done, seq_len, rd_color} !== 15'b0) begin
            failures++;
            $display("FAIL reset outputs: {color,busy,done,len,rd}=%b required 0",
                     {color_out, busy, done, seq_len, rd_color});
        end
        rst_n = 1'b1;
        start = 1'b0;
        exp_len = 0;
        step();
        checks++;
        if ({color_out, busy, done, seq_len} !== 9'b0) begin
            failures++;
            $display("FAIL reset release idle: {color,busy,done,len}=%b required 0",
                     {color_out, busy, done, seq_len});
        end
    endtask

    task automatic test_readback(input string tag);
        logic [2:0] want;
        for (int i = 0; i < 16; i++) begin
            rd_idx = 4'(i);
            want = (i < exp_len) ? exp_seq[i] : 3'd0;
            step();
            checks++;
            if (rd_color !== want) begin
                failures++;
                $display("FAIL %s readback idx%0d: Rd_color=%0d required %0d", tag, i,
                         rd_color, want);
            end
        end
        rd_idx = '0;
    endtask

    task automatic test_first_round();
        play_round(1'b0, 1'b0, "first_round");
        test_readback("first_round");
    endtask

    task automatic test_back_to_back();
        for (int r = 2; r <= 10; r++) play_round(1'b0, 1'b0, $sformatf("round%0d", r));
        checks++;
        if (seq_len !== 4'(MAXL)) begin
            failures++;
            $display("FAIL saturate: Seq_len=%0d required %0d", seq_len, MAXL);
        end
        test_readback("full");
    endtask

    task automatic test_reset_mid_gap();
        bit seen_done = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        model_append(1'b0);
        repeat (ON + 1) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        exp_len = 0;
        checks++;
        if ({color_out, busy, done, seq_len} !== 9'b0) begin
            failures++;
            $display("FAIL reset mid gap: {color,busy,done,len}=%b required 0",
                     {color_out, busy, done, seq_len});
        end
        repeat (12) begin
            step();
            if (done) seen_done = 1'b1;
        end
        checks++;
        if (seen_done) begin
            failures++;
            $display("FAIL reset mid gap done pulse: seen=1 required 0");
        end
    endtask

    task automatic test_abort();
        bit seen_done = 1'b0;
        play_round(1'b0, 1'b0, "pre_abort1");
        play_round(1'b0, 1'b0, "pre_abort2");
        start = 1'b1;
        step();
        start = 1'b0;
        model_append(1'b0);
        repeat (ON + OFF + 1) step();
        checks++;
        if (color_out !== exp_seq[1]) begin
            failures++;
            $display("FAIL abort slot1 color: Color_out=%0d required %0d", color_out, exp_seq[1]);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        checks++;
        if ({color_out, busy, done, seq_len} !== {3'd0, 1'b0, 1'b0, 4'd3}) begin
            failures++;
            $display("FAIL abort: {color,busy,done,len}=%b required %b",
                     {color_out, busy, done, seq_len}, {3'd0, 1'b0, 1'b0, 4'd3});
        end
        repeat (10) begin
            step();
            if (done || busy) seen_done = 1'b1;
        end
        checks++;
        if (seen_done) begin
            failures++;
            $display("FAIL abort quiet: done/busy seen=1 required 0");
        end
        play_round(1'b0, 1'b0, "post_abort");
        test_readback("post_abort");
    endtask

    task automatic test_clear_start();
        play_round(1'b0, 1'b0, "pre_clear");
        checks++;
        if (seq_len !== 4'd5) begin
            failures++;
            $display("FAIL pre clear length: Seq_len=%0d required 5", seq_len);
        end
        play_round(1'b1, 1'b1, "clear_start");
        repeat (3) step();
        checks++;
        if ({busy, done, seq_len} !== {1'b0, 1'b0, 4'd1}) begin
            failures++;
            $display("FAIL start in show ignored: {busy,done,len}=%b required %b",
                     {busy, done, seq_len}, {1'b0, 1'b0, 4'd1});
        end
        test_readback("clear_start");
    endtask

    initial begin
        test_reset();
        test_first_round();
        test_back_to_back();
        test_reset_mid_gap();
        test_abort();
        test_clear_start();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
